// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX/MEM/WB handshake and hazard-result bundle for hazard_ctrl.
//   master : pipeline side, drives ID decode fields, stage transfers and results,
//            receives pause / operand-forward decisions and the div busy flag.
//   slave  : hazard_ctrl itself.
interface hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_raddr1;
  logic [4:0]  id_raddr2;
  logic        id_rf_we;
  logic [4:0]  id_waddr;
  logic        id_res_from_mem;
  logic        id_is_div;
  logic        ex_allow_in;
  logic        ex_to_mem;
  logic        mem_to_wb;
  logic        wb_retire;
  logic [31:0] ex_result;
  logic [31:0] mem_result;
  logic [31:0] wb_result;
  logic        pause;
  logic        addr1_occur;
  logic        addr2_occur;
  logic [31:0] addr1_forward;
  logic [31:0] addr2_forward;
  logic        ex_div_busy;

  modport master (
    output id_valid, id_raddr1, id_raddr2, id_rf_we, id_waddr, id_res_from_mem,
           id_is_div, ex_allow_in, ex_to_mem, mem_to_wb, wb_retire,
           ex_result, mem_result, wb_result,
    input  pause, addr1_occur, addr2_occur, addr1_forward, addr2_forward, ex_div_busy
  );

  modport slave (
    input  id_valid, id_raddr1, id_raddr2, id_rf_we, id_waddr, id_res_from_mem,
           id_is_div, ex_allow_in, ex_to_mem, mem_to_wb, wb_retire,
           ex_result, mem_result, wb_result,
    output pause, addr1_occur, addr2_occur, addr1_forward, addr2_forward, ex_div_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: register scoreboard and hazard scheduler for the 5-stage pipeline.
// Tracks the destination tag of the instruction in EX, MEM and WB and decides,
// combinationally from that state and the ID fields, whether ID must pause or
// may take a forwarded value for rj (operand 1) / rk-rd (operand 2). Also owns
// the divider occupancy counter that keeps EX from completing a div/mod early.
//
// Ports:
//   clk   - pipeline clock
//   reset - asynchronous, active-low reset
//   hz    - hazard_ctrl_if.slave (ID fields, stage transfers, results in;
//           pause, addrN_occur, addrN_forward, ex_div_busy out)
// Parameter:
//   DIV_LAT - cycles a div/mod occupies EX (1..63)
// Build option:
//   HAZARD_FORWARD_EN - defined: full forwarding; undefined: every match stalls
//                       and the occur/forward outputs are tied to 0.
module hazard_ctrl #(
  parameter int DIV_LAT = 33
) (
  input  logic   clk,
  input  logic   reset,
  hazard_ctrl_if.slave hz
);

  localparam int NUM_SLOT = 3;  // 0: EX, 1: MEM, 2: WB (youngest first)
  localparam int NUM_OPND = 2;  // 0: rj, 1: rk/rd
  localparam logic [5:0] DIV_INIT = 6'(DIV_LAT - 1);

  logic [NUM_SLOT-1:0]      slot_vld;
  logic [NUM_SLOT-1:0]      slot_we;
  logic [NUM_SLOT-1:0][4:0] slot_tag;
  logic                     ex_is_div;
  logic [5:0]               div_cnt;
  logic                     div_busy;
  logic                     fire;

  logic [NUM_OPND-1:0][4:0]  raddr;
  logic [NUM_OPND-1:0]       opnd_pause;
  logic [NUM_OPND-1:0]       occur;
  logic [NUM_OPND-1:0][31:0] fwd;

  assign raddr    = {hz.id_raddr2, hz.id_raddr1};
  assign div_busy = slot_vld[0] & ex_is_div & (div_cnt != 6'd0);
  assign fire     = hz.id_valid & ~hz.pause & hz.ex_allow_in;

  // Slot state. A transfer into a slot and a drain of that slot in the same
  // cycle resolves to the incoming entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_vld  <= '0;
      slot_we   <= '0;
      slot_tag  <= '0;
      ex_is_div <= 1'b0;
      div_cnt   <= '0;
    end else begin
      if (hz.mem_to_wb) begin
        slot_vld[2] <= slot_vld[1];
        slot_we[2]  <= slot_we[1];
        slot_tag[2] <= slot_tag[1];
      end else if (hz.wb_retire) begin
        slot_vld[2] <= 1'b0;
      end

      if (hz.ex_to_mem) begin
        slot_vld[1] <= slot_vld[0];
        slot_we[1]  <= slot_we[0];
        slot_tag[1] <= slot_tag[0];
      end else if (hz.mem_to_wb) begin
        slot_vld[1] <= 1'b0;
      end

      if (fire) begin
        slot_vld[0] <= 1'b1;
        slot_we[0]  <= hz.id_rf_we;
        slot_tag[0] <= hz.id_waddr;
        ex_is_div   <= hz.id_is_div;
      end else if (hz.ex_to_mem) begin
        slot_vld[0] <= 1'b0;
      end

      // Loaded with DIV_LAT-1: the issue edge itself counts as the first cycle.
      if (fire && hz.id_is_div) div_cnt <= DIV_INIT;
      else if (div_busy)        div_cnt <= div_cnt - 6'd1;
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Load flags matter only where forwarding decides; WB data is always ready.
  logic [1:0]                slot_ld;
  logic [NUM_SLOT-1:0]       blk;
  logic [NUM_SLOT-1:0][31:0] res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_ld <= '0;
    end else begin
      if (hz.ex_to_mem) slot_ld[1] <= slot_ld[0];
      if (fire)         slot_ld[0] <= hz.id_res_from_mem;
    end
  end

  assign blk = {1'b0, slot_ld[1], slot_ld[0] | div_busy};
  assign res = {hz.wb_result, hz.mem_result, hz.ex_result};
`endif

  for (genvar o = 0; o < NUM_OPND; o++) begin : g_opnd
    logic any_hit;
`ifdef HAZARD_FORWARD_EN
    logic        stall;
    logic [31:0] val;
`endif

    always_comb begin
      any_hit = 1'b0;
`ifdef HAZARD_FORWARD_EN
      stall = 1'b0;
      val   = '0;
`endif
      // Walk oldest to youngest so the youngest matching producer wins.
      for (int s = NUM_SLOT - 1; s >= 0; s--) begin
        if (hz.id_valid && slot_vld[s] && slot_we[s] &&
            slot_tag[s] == raddr[o] && raddr[o] != 5'd0) begin
          any_hit = 1'b1;
`ifdef HAZARD_FORWARD_EN
          stall = blk[s];
          val   = res[s];
`endif
        end
      end
    end

`ifdef HAZARD_FORWARD_EN
    assign opnd_pause[o] = any_hit & stall;
    assign occur[o]      = any_hit & ~stall;
    assign fwd[o]        = (any_hit & ~stall) ? val : 32'd0;
`else
    assign opnd_pause[o] = any_hit;
    assign occur[o]      = 1'b0;
    assign fwd[o]        = 32'd0;
`endif
  end

  assign hz.pause         = |opnd_pause;
  assign hz.addr1_occur   = occur[0];
  assign hz.addr2_occur   = occur[1];
  assign hz.addr1_forward = fwd[0];
  assign hz.addr2_forward = fwd[1];
  assign hz.ex_div_busy   = div_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();
  hazard_ctrl #(.DIV_LAT(DIV_LAT)) dut (.clk(clk), .reset(reset), .hz(hz));

  typedef struct {
    bit        id_valid, we, ld, dv, allow, e2m, m2w, ret;
    bit [4:0]  ra1, ra2, wa;
    bit [31:0] exr, memr, wbr;
  } stim_t;

  typedef struct {
    string     nm;
    bit        pause, o1, o2, busy;
    bit [31:0] f1, f2;
  } exp_t;

  // Reference pipeline: one entry per stage, div latency tracked by issue cycle.
  typedef struct {
    bit       v, we, ld, dv;
    bit [4:0] wa;
    int       issue;
  } ent_t;

  ent_t st[3];
  int   cyc;
  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   busy_seen = 0;
  exp_t me;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) st[k] = '{default: 0};
  endfunction

  function automatic bit model_busy();
    return st[0].v && st[0].dv && ((cyc - st[0].issue) < (DIV_LAT - 1));
  endfunction

  function automatic void opnd(input stim_t s, input bit [4:0] a,
                               output bit p, output bit oc, output bit [31:0] f);
    p = 0; oc = 0; f = 0;
    if (!s.id_valid || a == 5'd0) return;
    for (int k = 0; k < 3; k++) begin
      if (st[k].v && st[k].we && st[k].wa == a) begin
`ifdef HAZARD_FORWARD_EN
        if ((k == 0 && (st[0].ld || model_busy())) || (k == 1 && st[1].ld)) p = 1;
        else begin
          oc = 1;
          f  = (k == 0) ? s.exr : (k == 1) ? s.memr : s.wbr;
        end
`else
        p = 1;
`endif
        return;
      end
    end
  endfunction

  function automatic exp_t model_eval(input stim_t s);
    exp_t e;
    bit p1, p2;
    e.busy = model_busy();
    opnd(s, s.ra1, p1, e.o1, e.f1);
    opnd(s, s.ra2, p2, e.o2, e.f2);
    e.pause = p1 | p2;
    return e;
  endfunction

  function automatic void model_step(input stim_t s, input bit pause);
    ent_t o[3];
    bit fire;
    if (!reset) return;
    o = st;
    cyc++;
    fire = s.id_valid && !pause && s.allow;
    if (s.m2w) st[2] = o[1]; else if (s.ret) st[2].v = 0;
    if (s.e2m) st[1] = o[0]; else if (s.m2w) st[1].v = 0;
    if (fire) st[0] = '{v: 1, we: s.we, ld: s.ld, dv: s.dv, wa: s.wa, issue: cyc};
    else if (s.e2m) st[0].v = 0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.ret   = ($urandom % 2 == 1) && st[2].v;
    s.m2w   = ($urandom % 2 == 1) && st[1].v && (!st[2].v || s.ret);
    s.e2m   = ($urandom % 2 == 1) && st[0].v && !model_busy() && (!st[1].v || s.m2w);
    s.allow = !st[0].v || s.e2m;
    s.id_valid = ($urandom % 4 != 0);
    s.ra1  = 5'($urandom % 8);
    s.ra2  = 5'($urandom % 8);
    s.wa   = 5'($urandom % 8);
    s.we   = ($urandom % 4 != 0);
    s.ld   = ($urandom % 4 == 0);
    s.dv   = !s.ld && ($urandom % 24 == 0);
    s.exr  = $urandom;
    s.memr = $urandom;
    s.wbr  = $urandom;
    return s;
  endfunction

  // Called at posedge+1: drive, record expectation, advance model at the edge.
  task automatic apply(input stim_t s, input string nm);
    exp_t e;
    hz.id_valid        = s.id_valid;
    hz.id_raddr1       = s.ra1;
    hz.id_raddr2       = s.ra2;
    hz.id_rf_we        = s.we;
    hz.id_waddr        = s.wa;
    hz.id_res_from_mem = s.ld;
    hz.id_is_div       = s.dv;
    hz.ex_allow_in     = s.allow;
    hz.ex_to_mem       = s.e2m;
    hz.mem_to_wb       = s.m2w;
    hz.wb_retire       = s.ret;
    hz.ex_result       = s.exr;
    hz.mem_result      = s.memr;
    hz.wb_result       = s.wbr;
    e = model_eval(s);
    e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    model_step(s, e.pause);
    #1;
  endtask

  task automatic drain();
    stim_t s;
    repeat (4) begin
      s = idle();
      s.ret = st[2].v;
      s.m2w = st[1].v;
      s.e2m = st[0].v && !model_busy();
      apply(s, "drain");
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    if (hz.ex_div_busy === 1'b1) busy_seen++;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk({me.nm, "_pause"}, 32'(hz.pause), 32'(me.pause));
      chk({me.nm, "_busy"}, 32'(hz.ex_div_busy), 32'(me.busy));
      if (!me.pause) begin
        chk({me.nm, "_occur1"}, 32'(hz.addr1_occur), 32'(me.o1));
        chk({me.nm, "_fwd1"}, hz.addr1_forward, me.f1);
        chk({me.nm, "_occur2"}, 32'(hz.addr2_occur), 32'(me.o2));
        chk({me.nm, "_fwd2"}, hz.addr2_forward, me.f2);
      end
    end
  end

  initial begin
    stim_t s;
    model_clear();
    cyc = 0;
    @(posedge clk);
    #1;
    s = idle(); s.id_valid = 1; s.ra1 = 5;
    apply(s, "rst_hold");
    reset = 1'b1;
    s = idle(); s.id_valid = 1; s.we = 1; s.wa = 5; s.allow = 1;
    apply(s, "load_ex");
    // Asynchronous reset with EX occupied.
    reset = 1'b0;
    model_clear();
    s = idle(); s.id_valid = 1; s.ra1 = 5;
    apply(s, "rst_mid");
    reset = 1'b1;
    apply(s, "rst_after");

    // add r5 -> use
    s = idle(); s.id_valid = 1; s.we = 1; s.wa = 5; s.allow = 1;
    apply(s, "add_issue");
    s = idle(); s.id_valid = 1; s.ra1 = 5; s.exr = 32'h1234;
    apply(s, "add_use");
    drain();

    // ld.w r7 through EX, MEM, WB
    s = idle(); s.id_valid = 1; s.we = 1; s.wa = 7; s.ld = 1; s.allow = 1;
    apply(s, "ld_issue");
    s = idle(); s.id_valid = 1; s.ra1 = 7; s.wbr = 32'hCAFE;
    apply(s, "ld_ex");
    s.e2m = 1;
    apply(s, "ld_ex_go");
    s.e2m = 0; s.m2w = 1;
    apply(s, "ld_mem");
    s.m2w = 0;
    apply(s, "ld_wb");
    drain();

    // r3 in WB and EX simultaneously
    s = idle(); s.id_valid = 1; s.we = 1; s.wa = 3; s.allow = 1;
    apply(s, "r3a_issue");
    s = idle(); s.e2m = 1;
    apply(s, "r3a_mem");
    s = idle(); s.id_valid = 1; s.we = 1; s.wa = 3; s.allow = 1; s.m2w = 1;
    apply(s, "r3b_issue");
    s = idle(); s.id_valid = 1; s.ra1 = 3; s.ra2 = 3;
    s.exr = 32'hAAAA; s.memr = 32'h1111; s.wbr = 32'hBBBB;
    apply(s, "r3_use");
    drain();

    // div.w r4 and a dependent reader
    s = idle(); s.id_valid = 1; s.we = 1; s.wa = 4; s.dv = 1; s.allow = 1;
    apply(s, "div_issue");
    busy_seen = 0;
    for (int i = 0; i < DIV_LAT + 2; i++) begin
      s = idle(); s.id_valid = 1; s.ra2 = 4; s.exr = $urandom;
      apply(s, "div_use");
    end
    chk("div_busy_cycles", 32'(busy_seen), 32'(DIV_LAT - 1));
    drain();

    // write to r0 never hazards
    s = idle(); s.id_valid = 1; s.we = 1; s.wa = 0; s.allow = 1;
    apply(s, "r0_issue");
    s = idle(); s.id_valid = 1; s.ra1 = 0; s.ra2 = 0; s.exr = 32'h55;
    apply(s, "r0_use");
    drain();

    for (int i = 0; i < 2500; i++) apply(rand_stim(), "rand");
    drain();

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
